// File: rtl/btb_assoc_pkg.sv
// Shared types for the set-associative BTB: entry layout and flush FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Field widths follow the BTB_* constants below, so a btb_assoc
// instance whose parameters differ from them needs these constants to match.
package btb_pkg;

  localparam int BTB_XLEN     = 32;
  localparam int BTB_SETS     = 16;
  localparam int BTB_WAYS     = 2;
  localparam int BTB_CNT_BITS = 2;
  localparam int BTB_IDX_BITS = $clog2(BTB_SETS);
  localparam int BTB_TAG_BITS = BTB_XLEN - BTB_IDX_BITS - 2;

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_BITS-1:0] tag;
    logic [BTB_XLEN-1:0]     target;
    logic                    tgt_known;
    logic [BTB_CNT_BITS-1:0] cnt;
  } BTB_ASSOC_ENTRY;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } FLUSH_STATE;

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch lookup, decode alloc, branch-resolve update and flush control of the BTB.
// Latency: lookup outputs are combinational; alloc/upd/flush_req sample on the clock edge.
// Backpressure: none per request; alloc/upd are dropped while flush_busy is high.
// Ports: lkp_* (fetch), alloc_* (decode), upd_* (branch FU), flush_req/flush_busy.
interface btb_assoc_if #(
  parameter int XLEN = 32
);

  logic            lkp_valid;
  logic [XLEN-1:0] lkp_pc;
  logic            lkp_hit;
  logic            lkp_taken;
  logic [XLEN-1:0] lkp_target;

  logic            alloc_valid;
  logic [XLEN-1:0] alloc_pc;

  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;

  logic            flush_req;
  logic            flush_busy;

  modport master (
    output lkp_valid, lkp_pc, alloc_valid, alloc_pc,
           upd_valid, upd_pc, upd_taken, upd_target, flush_req,
    input  lkp_hit, lkp_taken, lkp_target, flush_busy
  );

  modport slave (
    input  lkp_valid, lkp_pc, alloc_valid, alloc_pc,
           upd_valid, upd_pc, upd_taken, upd_target, flush_req,
    output lkp_hit, lkp_taken, lkp_target, flush_busy
  );

endinterface

// File: rtl/btb_sat_cnt.sv
// Saturating up/down direction counter step (no wrap at either end).
// Latency: combinational.
// Backpressure: n/a. Ports: cnt (current), taken (direction), cnt_next (stepped value).
module btb_sat_cnt #(
  parameter int CNT_BITS = 2
) (
  input  logic [CNT_BITS-1:0] cnt,
  input  logic                taken,
  output logic [CNT_BITS-1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != '1) cnt_next = cnt + 1'b1;
    end else begin
      if (cnt != '0) cnt_next = cnt - 1'b1;
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB with saturating direction counters and a one-set-per-cycle flush.
// Latency: lookup 0 cycles on registered state; writes visible the cycle after their edge.
// Backpressure: alloc/upd ignored while flush_busy; same-set alloc loses to upd.
// Ports: clock, reset (async active-low), bus (btb_assoc_if slave modport).
module btb_assoc
  import btb_pkg::*;
#(
  parameter int XLEN     = BTB_XLEN,
  parameter int SETS     = BTB_SETS,
  parameter int WAYS     = BTB_WAYS,
  parameter int CNT_BITS = BTB_CNT_BITS
) (
  input logic        clock,
  input logic        reset,
  btb_assoc_if.slave bus
);

  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = XLEN - IDX_BITS - 2;
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Fresh entries start weakly taken; an update-miss for a not-taken branch
  // starts one below that (weakly not taken).
  localparam logic [CNT_BITS-1:0] CNT_WEAK_T  = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_WEAK_NT = CNT_WEAK_T - CNT_BITS'(1);

  function automatic logic [IDX_BITS-1:0] idx_of(input logic [XLEN-1:0] pc);
    return pc[IDX_BITS+1:2];
  endfunction

  function automatic logic [TAG_BITS-1:0] tag_of(input logic [XLEN-1:0] pc);
    return pc[XLEN-1:IDX_BITS+2];
  endfunction

  // Lowest-index invalid way wins; only a full set falls back to the victim.
  function automatic logic [WAY_BITS-1:0] way_select(input logic [WAYS-1:0]     vld,
                                                     input logic [WAY_BITS-1:0] victim);
    logic [WAY_BITS-1:0] w;
    logic                found;
    w     = victim;
    found = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!vld[i] && !found) begin
        w     = WAY_BITS'(i);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [WAY_BITS-1:0] victim_next(input logic [WAY_BITS-1:0] v);
    return (v == WAY_BITS'(WAYS - 1)) ? '0 : v + 1'b1;
  endfunction

  BTB_ASSOC_ENTRY      tbl_q    [SETS][WAYS];
  logic [WAY_BITS-1:0] victim_q [SETS];

  FLUSH_STATE          state_q, state_d;
  logic [IDX_BITS-1:0] fptr_q, fptr_d;
  logic                busy;

  assign busy           = (state_q == FLUSH);
  assign bus.flush_busy = busy;

  // ---------------------------------------------------------------- flush FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fptr_q  <= '0;
    end else begin
      state_q <= state_d;
      fptr_q  <= fptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fptr_d  = fptr_q;
    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          state_d = FLUSH;
          fptr_d  = '0;
        end
      end
      FLUSH: begin
        fptr_d = fptr_q + 1'b1;
        if (fptr_q == IDX_BITS'(SETS - 1)) begin
          state_d = IDLE;
          fptr_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        fptr_d  = '0;
      end
    endcase
  end

  // ------------------------------------------------------------ tag probes
  logic [IDX_BITS-1:0] l_idx, a_idx, u_idx;
  logic [TAG_BITS-1:0] l_tag, a_tag, u_tag;

  assign l_idx = idx_of(bus.lkp_pc);
  assign l_tag = tag_of(bus.lkp_pc);
  assign a_idx = idx_of(bus.alloc_pc);
  assign a_tag = tag_of(bus.alloc_pc);
  assign u_idx = idx_of(bus.upd_pc);
  assign u_tag = tag_of(bus.upd_pc);

  logic                l_match, a_hit, u_hit;
  logic [WAY_BITS-1:0] l_way, u_hit_way;
  logic [WAYS-1:0]     a_vvec, u_vvec;

  // A tag can live in at most one way of a set, so first-match is exact.
  always_comb begin
    l_match   = 1'b0;
    l_way     = '0;
    a_hit     = 1'b0;
    u_hit     = 1'b0;
    u_hit_way = '0;
    a_vvec    = '0;
    u_vvec    = '0;
    for (int w = 0; w < WAYS; w++) begin
      a_vvec[w] = tbl_q[a_idx][w].valid;
      u_vvec[w] = tbl_q[u_idx][w].valid;
      if (!l_match && tbl_q[l_idx][w].valid && tbl_q[l_idx][w].tag == l_tag) begin
        l_match = 1'b1;
        l_way   = WAY_BITS'(w);
      end
      if (tbl_q[a_idx][w].valid && tbl_q[a_idx][w].tag == a_tag) begin
        a_hit = 1'b1;
      end
      if (!u_hit && tbl_q[u_idx][w].valid && tbl_q[u_idx][w].tag == u_tag) begin
        u_hit     = 1'b1;
        u_hit_way = WAY_BITS'(w);
      end
    end
  end

  // ---------------------------------------------------------------- lookup
  BTB_ASSOC_ENTRY l_ent;
  logic           l_hit;

  assign l_ent          = tbl_q[l_idx][l_way];
  assign l_hit          = bus.lkp_valid && !busy && l_match;
  assign bus.lkp_hit    = l_hit;
  assign bus.lkp_taken  = l_hit && l_ent.cnt[CNT_BITS-1] && l_ent.tgt_known;
  assign bus.lkp_target = l_hit ? l_ent.target : '0;

  // ------------------------------------------------------- write decisions
  logic                upd_do, alloc_do;
  logic [WAY_BITS-1:0] u_way, a_way;
  logic [CNT_BITS-1:0] u_cnt_next;

  assign upd_do   = bus.upd_valid && !busy;
  assign alloc_do = bus.alloc_valid && !busy && !a_hit && !(upd_do && (u_idx == a_idx));
  assign u_way    = u_hit ? u_hit_way : way_select(u_vvec, victim_q[u_idx]);
  assign a_way    = way_select(a_vvec, victim_q[a_idx]);

  btb_sat_cnt #(
    .CNT_BITS (CNT_BITS)
  ) u_sat_cnt (
    .cnt      (tbl_q[u_idx][u_hit_way].cnt),
    .taken    (bus.upd_taken),
    .cnt_next (u_cnt_next)
  );

  // ------------------------------------------------------------ table state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tbl_q[s][w] <= '0;
        end
        victim_q[s] <= '0;
      end
    end else begin
      if (busy) begin
        for (int w = 0; w < WAYS; w++) begin
          tbl_q[fptr_q][w].valid <= 1'b0;
        end
        victim_q[fptr_q] <= '0;
      end

      if (upd_do) begin
        tbl_q[u_idx][u_way].target    <= bus.upd_target;
        tbl_q[u_idx][u_way].tgt_known <= 1'b1;
        if (u_hit) begin
          tbl_q[u_idx][u_way].cnt <= u_cnt_next;
        end else begin
          tbl_q[u_idx][u_way].valid <= 1'b1;
          tbl_q[u_idx][u_way].tag   <= u_tag;
          tbl_q[u_idx][u_way].cnt   <= bus.upd_taken ? CNT_WEAK_T : CNT_WEAK_NT;
          if (&u_vvec) victim_q[u_idx] <= victim_next(victim_q[u_idx]);
        end
      end

      if (alloc_do) begin
        tbl_q[a_idx][a_way].valid     <= 1'b1;
        tbl_q[a_idx][a_way].tag       <= a_tag;
        tbl_q[a_idx][a_way].target    <= '0;
        tbl_q[a_idx][a_way].tgt_known <= 1'b0;
        tbl_q[a_idx][a_way].cnt       <= CNT_WEAK_T;
        if (&a_vvec) victim_q[a_idx] <= victim_next(victim_q[a_idx]);
      end
    end
  end

  // PCs are word aligned; the low two bits carry no information here.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bus.lkp_pc[1:0], bus.alloc_pc[1:0], bus.upd_pc[1:0]};

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural table model.
module tb_btb_assoc;

  localparam int XLEN     = 32;
  localparam int SETS     = 16;
  localparam int WAYS     = 2;
  localparam int CNT_BITS = 2;
  localparam int IDX_BITS = $clog2(SETS);
  localparam int CNT_MAX  = (1 << CNT_BITS) - 1;
  localparam int CNT_HALF = 1 << (CNT_BITS - 1);

  logic clock;
  logic reset;

  btb_assoc_if #(.XLEN(XLEN)) bus ();

  btb_assoc #(
    .XLEN     (XLEN),
    .SETS     (SETS),
    .WAYS     (WAYS),
    .CNT_BITS (CNT_BITS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------ behavioural model
  bit              m_v   [SETS][WAYS];
  logic [XLEN-1:0] m_tag [SETS][WAYS];
  logic [XLEN-1:0] m_tgt [SETS][WAYS];
  bit              m_k   [SETS][WAYS];
  int              m_cnt [SETS][WAYS];
  int              m_vic [SETS];
  bit              m_busy;
  int              m_fptr;

  function automatic int set_of(input logic [XLEN-1:0] pc);
    return int'((pc / 4) % SETS);
  endfunction

  function automatic logic [XLEN-1:0] tag_of(input logic [XLEN-1:0] pc);
    return pc / (4 * SETS);
  endfunction

  function automatic int m_find(input int s, input logic [XLEN-1:0] t);
    for (int w = 0; w < WAYS; w++)
      if (m_v[s][w] && m_tag[s][w] == t) return w;
    return -1;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_v[s][w] = 0; m_tag[s][w] = '0; m_tgt[s][w] = '0; m_k[s][w] = 0; m_cnt[s][w] = 0;
      end
      m_vic[s] = 0;
    end
    m_busy = 0;
    m_fptr = 0;
  endtask

  task automatic model_place(input int s, input logic [XLEN-1:0] t, input logic [XLEN-1:0] tgt,
                             input bit k, input int c);
    int w;
    w = -1;
    for (int i = WAYS - 1; i >= 0; i--) if (!m_v[s][i]) w = i;
    if (w < 0) begin
      w        = m_vic[s];
      m_vic[s] = (m_vic[s] + 1) % WAYS;
    end
    m_v[s][w] = 1; m_tag[s][w] = t; m_tgt[s][w] = tgt; m_k[s][w] = k; m_cnt[s][w] = c;
  endtask

  task automatic model_step();
    int  us, as, uw;
    bit  alloc_ok;
    if (m_busy) begin
      for (int w = 0; w < WAYS; w++) m_v[m_fptr][w] = 0;
      m_vic[m_fptr] = 0;
      m_fptr++;
      if (m_fptr == SETS) m_busy = 0;
    end else begin
      if (bus.flush_req) begin
        m_busy = 1;
        m_fptr = 0;
      end
      us       = set_of(bus.upd_pc);
      as       = set_of(bus.alloc_pc);
      alloc_ok = bus.alloc_valid && !(bus.upd_valid && us == as) &&
                 m_find(as, tag_of(bus.alloc_pc)) < 0;
      if (bus.upd_valid) begin
        uw = m_find(us, tag_of(bus.upd_pc));
        if (uw >= 0) begin
          m_tgt[us][uw] = bus.upd_target;
          m_k[us][uw]   = 1;
          if (bus.upd_taken) m_cnt[us][uw] = (m_cnt[us][uw] < CNT_MAX) ? m_cnt[us][uw] + 1 : CNT_MAX;
          else               m_cnt[us][uw] = (m_cnt[us][uw] > 0) ? m_cnt[us][uw] - 1 : 0;
        end else begin
          model_place(us, tag_of(bus.upd_pc), bus.upd_target, 1,
                      bus.upd_taken ? CNT_HALF : CNT_HALF - 1);
        end
      end
      if (alloc_ok) model_place(as, tag_of(bus.alloc_pc), '0, 0, CNT_HALF);
    end
  endtask

  always @(negedge reset) model_clear();

  always @(posedge clock) begin
    if (reset) model_step();
  end

  // Every cycle, well after inputs settle, compare outputs with the model.
  always @(negedge clock) begin
    int  s, w;
    bit  eh, et;
    logic [XLEN-1:0] etg;
    #3;
    s   = set_of(bus.lkp_pc);
    w   = m_find(s, tag_of(bus.lkp_pc));
    eh  = bus.lkp_valid && !m_busy && (w >= 0);
    et  = eh && m_k[s][w] && (m_cnt[s][w] >= CNT_HALF);
    etg = eh ? m_tgt[s][w] : '0;
    chk("model_hit",    bus.lkp_hit,    eh);
    chk("model_taken",  bus.lkp_taken,  et);
    chk("model_target", bus.lkp_target, etg);
    chk("model_busy",   bus.flush_busy, m_busy);
  end

  // ------------------------------------------------------------- stimulus
  task automatic step_in(input bit lv, input logic [XLEN-1:0] lp,
                         input bit av, input logic [XLEN-1:0] ap,
                         input bit uv, input logic [XLEN-1:0] up, input bit ut,
                         input logic [XLEN-1:0] utg, input bit fl);
    @(negedge clock);
    #1;
    bus.lkp_valid   = lv;  bus.lkp_pc     = lp;
    bus.alloc_valid = av;  bus.alloc_pc   = ap;
    bus.upd_valid   = uv;  bus.upd_pc     = up;
    bus.upd_taken   = ut;  bus.upd_target = utg;
    bus.flush_req   = fl;
  endtask

  task automatic idle();
    step_in(0, '0, 0, '0, 0, '0, 0, '0, 0);
  endtask

  task automatic alloc(input logic [XLEN-1:0] pc);
    step_in(0, '0, 1, pc, 0, '0, 0, '0, 0);
  endtask

  task automatic upd(input logic [XLEN-1:0] pc, input bit tk, input logic [XLEN-1:0] tgt);
    step_in(0, '0, 0, '0, 1, pc, tk, tgt, 0);
  endtask

  task automatic look(input string nm, input logic [XLEN-1:0] pc,
                      input bit eh, input bit et, input logic [XLEN-1:0] etg);
    step_in(1, pc, 0, '0, 0, '0, 0, '0, 0);
    #1;
    chk({nm, "_hit"},    bus.lkp_hit,    eh);
    chk({nm, "_taken"},  bus.lkp_taken,  et);
    chk({nm, "_target"}, bus.lkp_target, etg);
  endtask

  function automatic logic [XLEN-1:0] rand_pc();
    logic [XLEN-1:0] t, i;
    t = XLEN'($urandom_range(0, 4));
    i = XLEN'($urandom_range(0, 3));
    return (t << 6) | (i << 2);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nbusy;
    model_clear();
    reset = 1'b0;
    bus.lkp_valid = 0; bus.lkp_pc = '0; bus.alloc_valid = 0; bus.alloc_pc = '0;
    bus.upd_valid = 0; bus.upd_pc = '0; bus.upd_taken = 0; bus.upd_target = '0;
    bus.flush_req = 0;

    // Outputs held quiet in reset even with a lookup presented.
    step_in(1, 32'h100, 0, '0, 0, '0, 0, '0, 0);
    #1;
    chk("rst_hit",    bus.lkp_hit,    1'b0);
    chk("rst_taken",  bus.lkp_taken,  1'b0);
    chk("rst_target", bus.lkp_target, '0);
    chk("rst_busy",   bus.flush_busy, 1'b0);
    idle();
    reset = 1'b1;

    // Alloc then lookup; then train target.
    look("cold", 32'h100, 0, 0, '0);
    alloc(32'h100);
    look("alloc", 32'h100, 1, 0, '0);
    upd(32'h100, 1, 32'h200);
    look("trained", 32'h100, 1, 1, 32'h200);

    // Counter 3 -> four not-taken saturates at 0; taken -> 1 (not taken); taken -> 2.
    repeat (4) upd(32'h100, 0, 32'h200);
    look("nt_sat", 32'h100, 1, 0, 32'h200);
    upd(32'h100, 1, 32'h200);
    look("cnt1", 32'h100, 1, 0, 32'h200);
    upd(32'h100, 1, 32'h200);
    look("cnt2", 32'h100, 1, 1, 32'h200);

    // Set 0 replacement: 0x140 fills way 1, 0x180 evicts victim way 0 (0x100).
    alloc(32'h140);
    alloc(32'h180);
    look("evicted", 32'h100, 0, 0, '0);
    look("kept",    32'h140, 1, 0, '0);
    look("new",     32'h180, 1, 0, '0);
    alloc(32'h140);
    look("realloc_noop", 32'h180, 1, 0, '0);

    // Same-set alloc + update in one cycle: update wins.
    step_in(0, '0, 1, 32'h104, 1, 32'h144, 1, 32'h300, 0);
    look("dropped", 32'h104, 0, 0, '0);
    look("upd_alloc", 32'h144, 1, 1, 32'h300);

    // Flush with four live entries.
    alloc(32'h108);
    step_in(0, '0, 0, '0, 0, '0, 0, '0, 1);
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      look("in_flush", 32'h140, 0, 0, '0);
      if (bus.flush_busy) nbusy++;
      else if (nbusy > 0) break;
    end
    chk("flush_len", nbusy, SETS);
    look("fl_140", 32'h140, 0, 0, '0);
    look("fl_180", 32'h180, 0, 0, '0);
    look("fl_144", 32'h144, 0, 0, '0);
    look("fl_108", 32'h108, 0, 0, '0);
    alloc(32'h100);
    look("post_flush", 32'h100, 1, 0, '0);

    // Reset during the fifth flush cycle aborts it.
    step_in(0, '0, 0, '0, 0, '0, 0, '0, 1);
    repeat (5) idle();
    chk("mid_busy_pre", bus.flush_busy, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_busy_rst", bus.flush_busy, 1'b0);
    @(negedge clock);
    #1;
    reset = 1'b1;
    look("rst_clear", 32'h100, 0, 0, '0);
    step_in(0, '0, 0, '0, 0, '0, 0, '0, 1);
    idle();
    #1;
    chk("reflush_busy", bus.flush_busy, 1'b1);
    for (int i = 0; i < 40 && bus.flush_busy; i++) idle();
    chk("reflush_done", bus.flush_busy, 1'b0);

    // Randomized traffic on a small PC pool to force hits, misses and evictions.
    for (int c = 0; c < 3000; c++) begin
      step_in($urandom_range(0, 9) < 8, rand_pc(),
              $urandom_range(0, 9) < 3, rand_pc(),
              $urandom_range(0, 9) < 4, rand_pc(), 1'($urandom_range(0, 1)),
              XLEN'($urandom) & ~XLEN'(3),
              $urandom_range(0, 199) == 0);
    end
    idle();
    @(negedge clock);
    #5;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer with N-bit saturating direction counters, replacing the direct-mapped 2-bit BTB in the fetch stage. Fetch looks it up combinationally each cycle, decode allocates entries for newly seen branches, and the branch FU trains direction and target on resolution. Replacement is per-set round-robin with invalid-way preference. A multi-cycle flush sequencer clears the table one set per cycle.

## Interface
Parameters:
- XLEN, 32: PC width.
- SETS, 16: number of sets; power of two, ≥2.
- WAYS, 2: associativity; power of two, ≥1.
- CNT_BITS, 2: direction counter width, ≥1.
- Derived: IDX_BITS = log2(SETS); TAG_BITS = XLEN-IDX_BITS-2; WAY_BITS = max(1, log2(WAYS)).

Ports:
- clock  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- lkp_valid  in  1  fetch lookup request.
- lkp_pc  in  XLEN  fetch PC.
- lkp_hit  out  1  valid entry with matching tag.
- lkp_taken  out  1  predict taken.
- lkp_target  out  XLEN  predicted target; 0 when !lkp_hit.
- alloc_valid  in  1  decode saw a branch.
- alloc_pc  in  XLEN  its PC.
- upd_valid  in  1  branch resolved.
- upd_pc  in  XLEN  resolved branch PC.
- upd_taken  in  1  actual direction.
- upd_target  in  XLEN  actual target.
- flush_req  in  1  start table flush.
- flush_busy  out  1  flush in progress.

## Operation
- Index = pc[IDX_BITS+1:2]; tag = pc[XLEN-1:IDX_BITS+2]. Entry: valid, tag, target, tgt_known, cnt[CNT_BITS-1:0]. Per set: victim pointer, WAY_BITS wide.
- Lookup is combinational on registered state, with no bypass of same-cycle writes. A hit requires lkp_valid, !flush_busy, valid, and tag match. lkp_taken = hit & cnt[MSB] & tgt_known.
- Alloc on an existing tag is a no-op: counter and target are preserved. On a miss, allocation picks the lowest-index invalid way. If no way is invalid, it picks the victim way and increments the victim pointer, wrapping modulo WAYS. The new entry gets valid=1, tgt_known=0, target=0, cnt=2^(CNT_BITS-1) (weakly taken).
- Update on a hit sets target=upd_target and tgt_known=1. The counter increments on taken and saturates at 2^CNT_BITS-1. It decrements on not-taken and saturates at 0.
- Update on a miss allocates using the same way selection as alloc. The new entry gets tgt_known=1, target=upd_target, and cnt=2^(CNT_BITS-1) if taken, else 2^(CNT_BITS-1)-1.
- Alloc and update in the same set in the same cycle: the update is performed and the alloc is dropped. Different sets are processed independently.
- Flush FSM states:
  - IDLE: flush_req → FLUSH with set pointer=0.
  - FLUSH: each cycle, clear valid in all ways of the pointed set and clear its victim pointer, then increment the pointer. After clearing set SETS-1 → IDLE.
  - flush_busy=1 exactly in FLUSH. lkp_hit=0, and alloc/upd are ignored while busy. flush_req while busy is ignored.

## Timing
- Reset (async assert) clears all valid bits, counters, targets, victim pointers, and the flush pointer, and forces IDLE. Outputs while in reset: lkp_hit=0, lkp_taken=0, lkp_target=0, flush_busy=0. Reset asserted mid-flush aborts the flush to IDLE.
- Lookup latency is 0 cycles. A write on edge N is visible to lookups from cycle N+1.
- Flush takes exactly SETS cycles. flush_req sampled at edge N: flush_busy is high from N+1 through N+SETS. Alloc/upd are accepted again at edge N+SETS+1.
- Counter arithmetic is unsigned CNT_BITS with explicit saturation; no wrap.

## Structure
- Package btb_pkg: BTB_ASSOC_ENTRY struct (parametrised widths via package constants) and the FLUSH_STATE enum {IDLE, FLUSH}.
- Sub-module btb_sat_cnt: combinational CNT_BITS saturating counter with inputs cnt and taken, and output next cnt. Also used by future predictors.
- Way select (invalid-first, else victim) is a combinational function in the top module.

## Test plan
- Alloc at PC 0x100, then lookup 0x100 on the next cycle → hit=1, taken=0 (tgt_known=0), target=0. Then upd taken with target 0x200 → lookup gives taken=1, target=0x200.
- CNT_BITS=2: four not-taken updates then lookup → taken=0, cnt=0. One taken update → still not taken (cnt=1).
- WAYS=2, SETS=16: allocate PCs 0x100, 0x140, 0x180, which all map to set 0 → 0x180 replaces way 0 (0x100 misses) and 0x140 still hits.
- Alloc 0x100 and upd 0x140 (same set) in the same cycle → only 0x140 is present, with tgt_known=1.
- Fill 4 entries, pulse flush_req → flush_busy is high for exactly SETS cycles, lookups miss throughout, and all entries miss afterwards.
- Assert reset low mid-flush (cycle 5) → flush_busy drops immediately, and after release all lookups miss and a new flush_req is accepted.
